aes_dec: RTL and testbench

- Iterative AES-128 decryption engine; one round per clock; the inverse of the existing iterative encryption block.
- Shares that block's handshake: Krdy loads the key, Drdy starts a block, BSY marks activity, Dvld marks a valid result.
- Key setup expands the cipher key forward once to obtain round key 10.
- Each block then runs the inverse key schedule on the fly, from K10 down to K0.

---
 rtl/aes_pkg.sv | 74 +++++++
 rtl/dec_core.sv | 73 +++++++
 rtl/aes_dec.sv | 133 +++++++++++++
 tb/tb_aes_dec.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: sizes, FSM state type, GF(2^8) helpers,
// S-box / inverse S-box and the round-constant table.
package aes_pkg;

  localparam int unsigned NR  = 10;
  localparam int unsigned BLK = 128;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_KEXP = 2'd1,
    S_DEC  = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int unsigned i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s;
    s = ginv(x);
    return s ^ rotl8(s, 1) ^ rotl8(s, 2) ^ rotl8(s, 3) ^ rotl8(s, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  // Round constant for the step producing round key idx+1 from round key idx.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/dec_core.sv
// Combinational datapath: one inverse cipher round plus one forward and
// one inverse AES-128 key-schedule step.
module dec_core
  import aes_pkg::*;
(
  input  logic [BLK-1:0] state_i,
  input  logic [BLK-1:0] rkey_i,
  input  logic           last_i,
  output logic [BLK-1:0] state_o,
  input  logic [BLK-1:0] fkey_i,
  input  logic [7:0]     frcon_i,
  output logic [BLK-1:0] fkey_o,
  input  logic [BLK-1:0] ikey_i,
  input  logic [7:0]     ircon_i,
  output logic [BLK-1:0] ikey_o
);

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] s0, s1, s2, s3;
    {s0, s1, s2, s3} = w;
    return {gmul(s0, 8'h0e) ^ gmul(s1, 8'h0b) ^ gmul(s2, 8'h0d) ^ gmul(s3, 8'h09),
            gmul(s0, 8'h09) ^ gmul(s1, 8'h0e) ^ gmul(s2, 8'h0b) ^ gmul(s3, 8'h0d),
            gmul(s0, 8'h0d) ^ gmul(s1, 8'h09) ^ gmul(s2, 8'h0e) ^ gmul(s3, 8'h0b),
            gmul(s0, 8'h0b) ^ gmul(s1, 8'h0d) ^ gmul(s2, 8'h09) ^ gmul(s3, 8'h0e)};
  endfunction

  logic [BLK-1:0] isr_sb;
  logic [BLK-1:0] ark;

  // Inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
  always_comb begin
    isr_sb = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        isr_sb[127 - 8*(4*c + r) -: 8] = inv_sbox(state_i[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]);
      end
    end
    ark     = isr_sb ^ rkey_i;
    state_o = ark;
    if (!last_i) begin
      for (int unsigned c = 0; c < 4; c++) begin
        state_o[127 - 32*c -: 32] = inv_mix_col(ark[127 - 32*c -: 32]);
      end
    end
  end

  logic [31:0] fw0, fw1, fw2, fw3;

  // Forward key step: K(i) -> K(i+1).
  always_comb begin
    fw0    = fkey_i[127:96] ^ sub_rot(fkey_i[31:0]) ^ {frcon_i, 24'h0};
    fw1    = fkey_i[95:64] ^ fw0;
    fw2    = fkey_i[63:32] ^ fw1;
    fw3    = fkey_i[31:0]  ^ fw2;
    fkey_o = {fw0, fw1, fw2, fw3};
  end

  logic [31:0] iw0, iw1, iw2, iw3;

  // Inverse key step: K(i) -> K(i-1); w3 is recovered first because w0 depends on it.
  always_comb begin
    iw3    = ikey_i[31:0]  ^ ikey_i[63:32];
    iw2    = ikey_i[63:32] ^ ikey_i[95:64];
    iw1    = ikey_i[95:64] ^ ikey_i[127:96];
    iw0    = ikey_i[127:96] ^ sub_rot(iw3) ^ {ircon_i, 24'h0};
    ikey_o = {iw0, iw1, iw2, iw3};
  end

endmodule

// File: rtl/aes_dec.sv
// Iterative AES-128 decryption: key setup expands forward to K10 once,
// each block then walks the key schedule backwards one round per clock.
module aes_dec
  import aes_pkg::*;
(
  input  logic           CLK,
  input  logic           RSTn,
  input  logic           EN,
  input  logic [BLK-1:0] Din,
  input  logic [BLK-1:0] Key,
  input  logic           Krdy,
  input  logic           Drdy,
  output logic [BLK-1:0] Dout,
  output logic           BSY,
  output logic           Dvld
);

  localparam logic [3:0] RND_LAST = 4'(NR);

  state_e         state_q, state_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [BLK-1:0] krgx_q, krgx_d;
  logic [BLK-1:0] krg_q, krg_d;
  logic [BLK-1:0] drg_q, drg_d;
  logic           kvld_q, kvld_d;
  logic           dvld_q, dvld_d;

  logic [BLK-1:0] round_o, fkey_o, ikey_o, ikey_i;
  logic [7:0]     frcon, ircon;
  logic           last;

  // From IDLE the inverse step starts at K10 (rcon 36); in DEC it follows the round counter.
  assign ikey_i = (state_q == S_IDLE) ? krg_q : krgx_q;
  assign ircon  = (state_q == S_IDLE) ? rcon(4'd9) : rcon(4'd9 - rnd_q);
  assign frcon  = rcon(rnd_q - 4'd1);
  assign last   = (rnd_q == RND_LAST);

  dec_core u_core (
    .state_i (drg_q),
    .rkey_i  (krgx_q),
    .last_i  (last),
    .state_o (round_o),
    .fkey_i  (krgx_q),
    .frcon_i (frcon),
    .fkey_o  (fkey_o),
    .ikey_i  (ikey_i),
    .ircon_i (ircon),
    .ikey_o  (ikey_o)
  );

  // Next-state logic: everything holds unless EN is high.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    krgx_d  = krgx_q;
    krg_d   = krg_q;
    drg_d   = drg_q;
    kvld_d  = kvld_q;
    dvld_d  = dvld_q;
    if (EN) begin
      case (state_q)
        S_IDLE: begin
          if (Krdy) begin
            krgx_d  = Key;
            dvld_d  = 1'b0;
            kvld_d  = 1'b0;
            rnd_d   = 4'd1;
            state_d = S_KEXP;
          end else if (Drdy && kvld_q) begin
            drg_d   = Din ^ krg_q;
            krgx_d  = ikey_o;
            dvld_d  = 1'b0;
            rnd_d   = 4'd1;
            state_d = S_DEC;
          end
        end
        S_KEXP: begin
          krgx_d = fkey_o;
          if (last) begin
            krg_d   = fkey_o;
            kvld_d  = 1'b1;
            rnd_d   = 4'd1;
            state_d = S_IDLE;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
        S_DEC: begin
          drg_d = round_o;
          if (last) begin
            krgx_d  = krg_q;
            dvld_d  = 1'b1;
            rnd_d   = 4'd1;
            state_d = S_IDLE;
          end else begin
            krgx_d = ikey_o;
            rnd_d  = rnd_q + 4'd1;
          end
        end
        default: begin
          rnd_d   = 4'd1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      rnd_q   <= 4'd1;
      krgx_q  <= '0;
      krg_q   <= '0;
      drg_q   <= '0;
      kvld_q  <= 1'b0;
      dvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      krgx_q  <= krgx_d;
      krg_q   <= krg_d;
      drg_q   <= drg_d;
      kvld_q  <= kvld_d;
      dvld_q  <= dvld_d;
    end
  end

  assign Dout = drg_q;
  assign BSY  = (state_q != S_IDLE);
  assign Dvld = dvld_q;

endmodule

// File: tb/tb_aes_dec.sv
// Self-checking bench for aes_dec: known-answer vectors, an independent
// encryption model for loopback, and handshake corner cases.
module tb_aes_dec;

  logic         CLK = 1'b0;
  logic         RSTn;
  logic         EN;
  logic [127:0] Din;
  logic [127:0] Key;
  logic         Krdy;
  logic         Drdy;
  logic [127:0] Dout;
  logic         BSY;
  logic         Dvld;

  aes_dec dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .EN   (EN),
    .Din  (Din),
    .Key  (Key),
    .Krdy (Krdy),
    .Drdy (Drdy),
    .Dout (Dout),
    .BSY  (BSY),
    .Dvld (Dvld)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   sbt[256];

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "simulation time limit");
  end

  // ---------------- reference encryption model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] knext(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbt[w3[23:16]], sbt[w3[15:8]], sbt[w3[7:0]], sbt[w3[31:24]]} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] k10(input logic [127:0] key);
    logic [127:0] k;
    logic [7:0]   rc;
    k  = key;
    rc = 8'h01;
    for (int r = 0; r < 10; r++) begin
      k  = knext(k, rc);
      rc = xt(rc);
    end
    return k;
  endfunction

  function automatic logic [31:0] mixc(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] s, t, k;
    logic [7:0]   rc;
    s  = pt ^ key;
    k  = key;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      k  = knext(k, rc);
      rc = xt(rc);
      for (int i = 0; i < 16; i++) s[127 - 8*i -: 8] = sbt[s[127 - 8*i -: 8]];
      t = s;
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          s[127 - 8*(4*c + rr) -: 8] = t[127 - 8*(4*((c + rr) % 4) + rr) -: 8];
      if (r < 10)
        for (int c = 0; c < 4; c++) s[127 - 32*c -: 32] = mixc(s[127 - 32*c -: 32]);
      s = s ^ k;
    end
    return s;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Key load; optionally raises Drdy in the same cycle, which must be dropped.
  task automatic load_key(input string tag, input logic [127:0] k, input logic with_drdy);
    int unsigned n;
    Key  = k;
    Krdy = 1'b1;
    Drdy = with_drdy;
    tick();
    Krdy = 1'b0;
    Drdy = 1'b0;
    n = 0;
    while (BSY && n < 40) begin
      n++;
      tick();
    end
    check({tag, "_kbsy"}, 128'(n), 128'(10));
    check({tag, "_krg"}, dut.krg_q, k10(k));
  endtask

  task automatic start_dec(input logic [127:0] ct, input logic [127:0] pt);
    Din  = ct;
    Drdy = 1'b1;
    exp_q.push_back(pt);
    tick();
    Drdy = 1'b0;
  endtask

  // done = edges already elapsed after the start edge; lat = expected edge of Dvld.
  task automatic wait_result(input string tag, input int unsigned done, input int unsigned lat);
    int unsigned  n;
    logic [127:0] e;
    n = done;
    while (!Dvld && n < 64) begin
      tick();
      n++;
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check({tag, "_lat"}, 128'(n), 128'(lat));
    check({tag, "_dvld"}, 128'(Dvld), 128'(1));
    check({tag, "_dout"}, Dout, e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]   p, q;
    logic [127:0] ka, kb, pa, pb, cb, k, pt;
    int unsigned  ca, cbv;

    // S-box generated from the 3 / 1/3 orbit, independent of the RTL's inversion method
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xt(p);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      sbt[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
    end while (p != 8'h01);
    sbt[0] = 8'h63;

    RSTn = 1'b0;
    EN   = 1'b1;
    Din  = '0;
    Key  = '0;
    Krdy = 1'b0;
    Drdy = 1'b0;
    tick();
    tick();
    check("rst_bsy", 128'(BSY), 128'(0));
    check("rst_dvld", 128'(Dvld), 128'(0));
    check("rst_dout", Dout, 128'(0));
    @(negedge CLK);
    RSTn = 1'b1;
    tick();

    // Drdy with no key loaded
    Din  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    Drdy = 1'b1;
    tick();
    Drdy = 1'b0;
    check("nokey_bsy", 128'(BSY), 128'(0));
    repeat (11) tick();
    check("nokey_dvld", 128'(Dvld), 128'(0));

    // Known-answer vector 1
    ka = 128'h000102030405060708090a0b0c0d0e0f;
    load_key("kat1", ka, 1'b0);
    check("kat1_krg_const", dut.krg_q, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    start_dec(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff);
    check("kat1_bsy0", 128'(BSY), 128'(1));
    wait_result("kat1", 0, 10);
    check("kat1_bsy_end", 128'(BSY), 128'(0));
    repeat (3) tick();
    check("hold_dvld", 128'(Dvld), 128'(1));
    check("hold_dout", Dout, 128'h00112233445566778899aabbccddeeff);

    // Krdy and Drdy together: key load only, Dvld cleared and not raised
    kb = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    Din = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    load_key("both", kb, 1'b1);
    check("both_krg_const", dut.krg_q, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("both_dvld", 128'(Dvld), 128'(0));

    // Known-answer vector 2
    start_dec(128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734);
    wait_result("kat2", 0, 10);

    // Back-to-back: second Drdy in the first IDLE cycle after Dvld
    pa = 128'h0123456789abcdeffedcba9876543210;
    pb = 128'hdeadbeef00000000ffffffff5a5aa5a5;
    start_dec(enc(kb, pa), pa);
    wait_result("b2b_a", 0, 10);
    ca = cyc;
    start_dec(enc(kb, pb), pb);
    wait_result("b2b_b", 0, 10);
    cbv = cyc;
    check("b2b_period", 128'(cbv - ca), 128'(11));

    // EN dropped for 5 cycles mid-decrypt
    cb = enc(kb, pa ^ pb);
    start_dec(cb, pa ^ pb);
    repeat (3) tick();
    EN = 1'b0;
    repeat (5) tick();
    check("en_bsy", 128'(BSY), 128'(1));
    check("en_dvld", 128'(Dvld), 128'(0));
    EN = 1'b1;
    wait_result("en", 8, 15);

    // Strobes while busy are dropped
    start_dec(enc(kb, pb), pb);
    repeat (2) tick();
    Din  = 128'h0;
    Key  = 128'h1;
    Drdy = 1'b1;
    Krdy = 1'b1;
    tick();
    Drdy = 1'b0;
    Krdy = 1'b0;
    wait_result("busy", 3, 10);
    check("busy_krg", dut.krg_q, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Asynchronous reset during round 4 aborts and invalidates the key
    start_dec(enc(kb, pa), pa);
    repeat (3) tick();
    #2;
    RSTn = 1'b0;
    #1;
    check("arst_bsy", 128'(BSY), 128'(0));
    check("arst_dvld", 128'(Dvld), 128'(0));
    check("arst_dout", Dout, 128'(0));
    exp_q.delete();
    @(negedge CLK);
    RSTn = 1'b1;
    tick();
    Din  = enc(kb, pa);
    Drdy = 1'b1;
    tick();
    Drdy = 1'b0;
    check("arst_nokey_bsy", 128'(BSY), 128'(0));
    repeat (11) tick();
    check("arst_nokey_dvld", 128'(Dvld), 128'(0));
    load_key("rekey", kb, 1'b0);
    start_dec(enc(kb, pa), pa);
    wait_result("rekey", 0, 10);

    // Encrypt/decrypt loopback with random keys and plaintexts
    for (int i = 0; i < 1000; i++) begin
      k  = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      load_key("rnd", k, 1'b0);
      start_dec(enc(k, pt), pt);
      wait_result("rnd", 0, 10);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
